// File: rtl/rpn_seq_if.sv
// rpn_seq_if: ROM fetch and stack/ALU command bus of the RPN sequencer
interface rpn_seq_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        pc;
    logic [7:0]        instr;
    logic [1:0]        st_op;
    logic [DATA_W-1:0] st_wdata;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_y;
    modport master(output pc, st_op, st_wdata, alu_op, input instr, alu_y);
    modport slave(input pc, st_op, st_wdata, alu_op, output instr, alu_y);
endinterface

// File: rtl/rpn_seq.sv
// rpn_seq: single-step RPN program sequencer driving an external stack and ALU; RPN_SEQ_RUN_EN adds free-run mode
module rpn_seq #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             step_n,
    input  logic             run,
    rpn_seq_if.master        bus,
    output logic [3:0]       depth,
    output logic             halted,
    output logic             error
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, ERROR} state_t;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);
    state_t            state, state_nxt, ok_nxt;
    logic [7:0]        pc, pc_nxt;
    logic [3:0]        depth_nxt;
    logic [2:0]        sync;
    logic [1:0]        op;
    logic              step, run_on, fail;
    assign step = sync[2] & ~sync[1];
`ifdef RPN_SEQ_RUN_EN
    assign run_on = run;
`else
    logic unused_run;
    assign unused_run = run;
    assign run_on = 1'b0;
`endif
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= IDLE;
            pc    <= '0;
            depth <= '0;
            sync  <= 3'b111;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            depth <= depth_nxt;
            sync  <= {sync[1:0], step_n};
        end
    end
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        depth_nxt    = depth;
        op           = 2'b00;
        fail         = 1'b0;
        bus.st_wdata = '0;
        bus.alu_op   = 2'b00;
        ok_nxt       = run_on ? FETCH : IDLE;
        case (state)
            IDLE:  state_nxt = (step | run_on) ? FETCH : IDLE;
            FETCH: state_nxt = EXEC;
            EXEC: begin
                state_nxt = ok_nxt;
                pc_nxt    = pc + 8'd1;
                case (bus.instr[7:5])
                    3'b001: begin
                        fail         = depth == DEPTH_L;
                        op           = 2'b01;
                        bus.st_wdata = DATA_W'(bus.instr[4:0]);
                        depth_nxt    = depth + 4'd1;
                    end
                    3'b010, 3'b011, 3'b100, 3'b101: begin
                        fail         = depth < 4'd2;
                        op           = 2'b11;
                        bus.alu_op   = bus.instr[6:5] - 2'b10;
                        bus.st_wdata = bus.alu_y;
                        depth_nxt    = depth - 4'd1;
                    end
                    3'b110: begin
                        fail      = depth == 4'd0;
                        op        = 2'b10;
                        depth_nxt = depth - 4'd1;
                    end
                    3'b111: begin
                        state_nxt = HALT;
                        pc_nxt    = pc;
                    end
                    default: ;
                endcase
                if (fail) begin
                    state_nxt = ERROR;
                    pc_nxt    = pc;
                    depth_nxt = depth;
                    op        = 2'b00;
                end
            end
            default: ;
        endcase
    end
    // A reset landing mid-EXEC must not let the stack see a command in that cycle
    assign bus.st_op = resetn ? op : 2'b00;
    assign bus.pc    = pc;
    assign halted    = state == HALT;
    assign error     = state == ERROR;
endmodule

// File: doc/rpn_seq.md
RPN_SEQ -- requirements
Module: rpn_seq

Interface
REQ-001 Parameter DEPTH, default 8, is the stack capacity in entries (2..15).
REQ-002 Parameter DATA_W, default 8, is the stack word width in bits (>=5).
REQ-003 CLOCK_50  in  1  the single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset; synchronous, active-low.
REQ-005 step_n  in  1  raw active-low step button, asynchronous to CLOCK_50.
REQ-006 run  in  1  free-run request (see Configuration).
REQ-007 pc  out  8  program counter, addresses the instruction ROM.
REQ-008 instr  in  8  ROM data; valid one cycle after pc changes.
REQ-009 st_op  out  2  stack command: 00 none, 01 push, 10 pop, 11 reduce (pop two, push st_wdata).
REQ-010 st_wdata  out  DATA_W  data pushed on push or reduce.
REQ-011 alu_op  out  2  external ALU select: 00 add, 01 sub, 10 and, 11 or.
REQ-012 alu_y  in  DATA_W  combinational ALU result of (next op top).
REQ-013 depth  out  4  current stack occupancy.
REQ-014 halted  out  1  high in HALT state.
REQ-015 error  out  1  high in ERROR state.

Function
REQ-016 step_n passes a 2-flop synchronizer then a falling-edge detector, producing a 1-cycle step pulse per press.
REQ-017 States: IDLE, FETCH, EXEC, HALT, ERROR; reset state IDLE.
REQ-018 IDLE->FETCH on step pulse; FETCH->EXEC unconditionally (ROM latency 1); EXEC->IDLE, HALT or ERROR per decode.
REQ-019 Step pulses outside IDLE are discarded, never queued.
REQ-020 Decode instr[7:5]: 000 NOP, 001 PUSHI (st_wdata = zero-extended instr[4:0]), 010 ADD, 011 SUB, 100 AND, 101 OR, 110 DROP, 111 HALT.
REQ-021 ALU instructions drive alu_op = instr[6:5] - 2'b10 mapping ADD..OR to 00..11, st_op = 11, st_wdata = alu_y, during the single EXEC cycle.
REQ-022 st_op is nonzero only during EXEC, exactly one cycle per executed instruction.
REQ-023 depth: +1 on push, -1 on pop or reduce, updated at the EXEC exit edge.
REQ-024 PUSHI with depth == DEPTH, ALU op with depth < 2, or DROP with depth == 0: st_op = 00, go to ERROR, pc and depth unchanged.
REQ-025 Successful NOP/PUSHI/ALU/DROP: pc increments by 1 at EXEC exit; 255 wraps to 0.
REQ-026 HALT: st_op = 00, pc unchanged, enter HALT.
REQ-027 HALT and ERROR are sticky; only reset leaves them; step and run ignored.
REQ-028 Step-to-pc latency: pc updates on the 3rd rising edge after the step pulse cycle.

Reset
REQ-029 With resetn low at a rising edge: state IDLE, pc 0, depth 0, st_op 00, st_wdata 0, alu_op 00, halted 0, error 0, synchronizer and edge flops cleared to idle level (high).
REQ-030 Reset in any state, including EXEC, takes effect at that edge; no stack command issues in that cycle or the cycle after.
REQ-031 While resetn is held low pc remains 0 regardless of step_n or run.

Configuration
REQ-032 Macro RPN_SEQ_RUN_EN compiled in: run = 1 in IDLE enters FETCH without a step, and a successful EXEC goes directly to FETCH, giving one instruction per 2 cycles; run = 0 behaves as step mode.
REQ-033 Macro RPN_SEQ_RUN_EN not defined: run port exists but is ignored; only step pulses advance execution.

Verification
REQ-034 Hold resetn low 4 cycles with step_n toggling -> pc = 0, st_op = 00, depth = 0 throughout.
REQ-035 Release reset, no press for 10 cycles -> pc stays 0, state IDLE.
REQ-036 ROM[0] = 8'h23 (PUSHI 3), one press -> single push cycle with st_wdata = 3, pc = 1 on 3rd edge after pulse, depth = 1.
REQ-037 ROM = PUSHI 3, PUSHI 5, ADD, HALT; four presses -> reduce cycle with alu_op = 00, st_wdata = alu_y = 8, depth = 1, halted = 1, pc = 3; fifth press -> no change.
REQ-038 ROM[0] = 8'h40 (ADD) with depth 0, one press -> error = 1, st_op stays 00, pc = 0; resetn pulse -> error = 0.
REQ-039 RPN_SEQ_RUN_EN defined, run = 1, ROM = 9 PUSHI then HALT with DEPTH = 8 -> 8 pushes on alternate cycles, 9th PUSHI gives error = 1, pc = 8, depth = 8.
